// File: rtl/proc_pkg.sv
// Shared types and constants for the boot loader slice.
// Holds the loader FSM encoding, instruction width and default base address.
package proc_pkg;

  localparam int IW = 32;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_0000;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    RUN,
    ERR
  } bl_state_e;

endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream valid/ready channel into the boot loader.
// master: stream source (drives valid/byte); slave: loader (drives ready).
interface boot_loader_if;

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_ready;

  modport master (
    output rx_valid,
    output rx_byte,
    input  rx_ready
  );

  modport slave (
    input  rx_valid,
    input  rx_byte,
    output rx_ready
  );

endinterface

// File: rtl/boot_loader_word_assembler.sv
// Packs little-endian stream bytes into a 32-bit word.
// Ports: clk, reset, in_byte, byte_idx, strobe -> word, word_valid (1-cycle).
module boot_loader_word_assembler
  import proc_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    in_byte,
  input  logic [1:0]    byte_idx,
  input  logic          strobe,
  output logic [IW-1:0] word,
  output logic          word_valid
);

  logic [IW-1:0] word_q;
  logic          wv_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      wv_q   <= 1'b0;
    end else begin
      // pulse lands in the cycle after the 4th byte,
      // when word_q already holds the full word
      wv_q <= strobe && (byte_idx == 2'd3);
      if (strobe)
        word_q[{byte_idx, 3'b000} +: 8] <= in_byte;
    end
  end

  assign word       = word_q;
  assign word_valid = wv_q;

endmodule

// File: rtl/boot_loader.sv
// Loads a length-prefixed, XOR-checksummed image into instruction RAM.
// Ports: clk, reset, rx (stream slave), imem_we/addr/wdata, cpu_reset, load_done, load_err.
module boot_loader
  import proc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic          clk,
  input  logic          reset,
  boot_loader_if.slave  rx,
  output logic          imem_we,
  output logic [31:0]   imem_addr,
  output logic [IW-1:0] imem_wdata,
  output logic          cpu_reset,
  output logic          load_done,
  output logic          load_err
);

  bl_state_e   state;
  bl_state_e   state_n;
  logic        rdy_q;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [15:0] len_full;
  logic [1:0]  byte_idx;
  logic [15:0] word_idx;
  logic [7:0]  csum;
  logic        acc;
  logic        strobe;
  logic        wv;
  logic        too_big;
  logic        last_byte;

  // ready is held low through the reset cycle itself
  assign rx.rx_ready = rdy_q &&
    (state inside {LEN_LO, LEN_HI, DATA, CHECK});

  assign acc       = rx.rx_valid && rx.rx_ready;
  assign strobe    = acc && (state == DATA);
  assign len_full  = {rx.rx_byte, len_lo};
  assign too_big   = {16'd0, len_full} > DEPTH_WORDS;
  assign last_byte = (byte_idx == 2'd3) &&
                     (word_idx == len - 16'd1);

  always_ff @(posedge clk) begin
    if (reset) state <= LEN_LO;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      LEN_LO: if (acc) state_n = LEN_HI;
      LEN_HI: begin
        if (acc) begin
          if (too_big)              state_n = ERR;
          else if (len_full == '0)  state_n = CHECK;
          else                      state_n = DATA;
        end
      end
      DATA:  if (acc && last_byte) state_n = CHECK;
      CHECK: begin
        if (acc)
          state_n = (rx.rx_byte == csum) ? RUN : ERR;
      end
      RUN:     state_n = RUN;
      ERR:     state_n = ERR;
      default: state_n = LEN_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdy_q     <= 1'b0;
      len_lo    <= '0;
      len       <= '0;
      byte_idx  <= '0;
      word_idx  <= '0;
      csum      <= '0;
      cpu_reset <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (acc && state == LEN_LO) len_lo <= rx.rx_byte;
      if (acc && state == LEN_HI) len    <= len_full;
      if (strobe) begin
        csum     <= csum ^ rx.rx_byte;
        byte_idx <= byte_idx + 2'd1;
      end
      // advance after the strobe so its address uses the old index
      if (wv) word_idx <= word_idx + 16'd1;
      load_done <= (state_n == RUN);
      load_err  <= (state_n == ERR);
      cpu_reset <= (state_n != RUN);
    end
  end

  boot_loader_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .in_byte    (rx.rx_byte),
    .byte_idx   (byte_idx),
    .strobe     (strobe),
    .word       (imem_wdata),
    .word_valid (wv)
  );

  // a strobe pending in the reset cycle is dropped
  assign imem_we   = wv && !reset;
  assign imem_addr = BASE_ADDR + {14'd0, word_idx, 2'b00};

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: stream scenarios with hand-computed results.
// Drives the rx interface, logs imem writes, checks status outputs.
module tb_boot_loader;

  logic        clk;
  logic        reset;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        load_done;
  logic        load_err;

  int total;
  int bad;

  logic [31:0] wa[$];
  logic [31:0] wd[$];

  boot_loader_if bus ();

  boot_loader dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (bus.slave),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wa.delete();
    wd.delete();
  endtask

  // caller is at a negedge; returns at the negedge after acceptance
  task automatic send(input logic [7:0] b, input bit gap);
    int n;
    n = 0;
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.rx_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_wait byte=%h ready=%b required=1",
               b, bus.rx_ready);
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
    if (gap) @(negedge clk);
  endtask

  task automatic send_image2(input logic [7:0] ck, input bit gap);
    logic [7:0] s [10];
    s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h20,
          8'hFF, 8'hFF, 8'hFF, 8'hFF};
    for (int i = 0; i < 10; i++) send(s[i], gap);
    total++;
    if (load_done !== 1'b0 || cpu_reset !== 1'b1) begin
      bad++;
      $display("FAIL pre_check done=%b cpu_rst=%b required=0/1",
               load_done, cpu_reset);
    end
    send(ck, gap);
  endtask

  task automatic check_writes2(input string tag);
    total++;
    if (wa.size() != 2) begin
      bad++;
      $display("FAIL %s_wr_count got=%0d required=2",
               tag, wa.size());
    end else begin
      if (wa[0] !== 32'h0 || wd[0] !== 32'h2000_0013) begin
        bad++;
        $display("FAIL %s_wr0 got=%h@%h required=20000013@0",
                 tag, wd[0], wa[0]);
      end
      total++;
      if (wa[1] !== 32'h4 || wd[1] !== 32'hFFFF_FFFF) begin
        bad++;
        $display("FAIL %s_wr1 got=%h@%h required=ffffffff@4",
                 tag, wd[1], wa[1]);
      end
    end
  endtask

  task automatic check_run(input string tag);
    total++;
    if (load_done !== 1'b1 || cpu_reset !== 1'b0 ||
        load_err !== 1'b0 || bus.rx_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s_run done=%b cpu_rst=%b err=%b rdy=%b required=1/0/0/0",
               tag, load_done, cpu_reset, load_err, bus.rx_ready);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_byte  = 8'hAA;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus.rx_ready !== 1'b0 || imem_we !== 1'b0 ||
        imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_bus rdy=%b we=%b addr=%h wd=%h required=0/0/0/0",
               bus.rx_ready, imem_we, imem_addr, imem_wdata);
    end
    total++;
    if (cpu_reset !== 1'b1 || load_done !== 1'b0 ||
        load_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_status cpu_rst=%b done=%b err=%b required=1/0/0",
               cpu_reset, load_done, load_err);
    end
    bus.rx_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (bus.rx_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release rdy=%b required=1", bus.rx_ready);
    end
    wa.delete();
    wd.delete();
  endtask

  task automatic test_load2();
    do_reset();
    send_image2(8'h33, 1'b0);
    check_run("load2");
    check_writes2("load2");
  endtask

  task automatic test_empty();
    do_reset();
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    check_run("empty");
    total++;
    if (wa.size() != 0) begin
      bad++;
      $display("FAIL empty_writes got=%0d required=0", wa.size());
    end
  endtask

  task automatic test_bad_checksum();
    do_reset();
    send_image2(8'h34, 1'b0);
    repeat (2) @(negedge clk);
    check_writes2("badsum");
    total++;
    if (load_err !== 1'b1 || cpu_reset !== 1'b1 ||
        bus.rx_ready !== 1'b0 || load_done !== 1'b0) begin
      bad++;
      $display("FAIL badsum_status err=%b cpu_rst=%b rdy=%b done=%b required=1/1/0/0",
               load_err, cpu_reset, bus.rx_ready, load_done);
    end
  endtask

  task automatic test_oversize();
    do_reset();
    send(8'h01, 1'b0);
    total++;
    if (load_err !== 1'b0) begin
      bad++;
      $display("FAIL oversize_early err=%b required=0", load_err);
    end
    send(8'h01, 1'b0);
    total++;
    if (load_err !== 1'b1 || cpu_reset !== 1'b1 ||
        bus.rx_ready !== 1'b0) begin
      bad++;
      $display("FAIL oversize_err err=%b cpu_rst=%b rdy=%b required=1/1/0",
               load_err, cpu_reset, bus.rx_ready);
    end
    bus.rx_valid = 1'b1;
    bus.rx_byte  = 8'h55;
    repeat (6) @(negedge clk);
    bus.rx_valid = 1'b0;
    total++;
    if (wa.size() != 0) begin
      bad++;
      $display("FAIL oversize_writes got=%0d required=0", wa.size());
    end
  endtask

  task automatic test_gapped();
    do_reset();
    send_image2(8'h33, 1'b1);
    check_run("gapped");
    check_writes2("gapped");
  endtask

  task automatic test_mid_reset();
    do_reset();
    send(8'h02, 1'b0);
    send(8'h00, 1'b0);
    send(8'h13, 1'b0);
    send(8'h00, 1'b0);
    do_reset();
    total++;
    if (imem_we !== 1'b0 || load_done !== 1'b0) begin
      bad++;
      $display("FAIL midrst_idle we=%b done=%b required=0/0",
               imem_we, load_done);
    end
    send_image2(8'h33, 1'b0);
    check_run("midrst");
    check_writes2("midrst");
  endtask

  task automatic test_reset_from_run();
    do_reset();
    send_image2(8'h33, 1'b0);
    check_run("rerun_pre");
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (cpu_reset !== 1'b1 || load_done !== 1'b0) begin
      bad++;
      $display("FAIL rerun_reset cpu_rst=%b done=%b required=1/0",
               cpu_reset, load_done);
    end
    reset = 1'b0;
    wa.delete();
    wd.delete();
    send_image2(8'h33, 1'b0);
    check_run("rerun");
    check_writes2("rerun");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    test_reset();
    test_load2();
    test_empty();
    test_bad_checksum();
    test_oversize();
    test_gapped();
    test_mid_reset();
    test_reset_from_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
